// File: rtl/dual_core_mem_arbiter.sv
// dual_core_mem_arbiter: round-robin arbiter sharing one single-port RAM between two cores.
// One owner per access; the RAM lines follow the owner combinationally while in SERVE.
module dual_core_mem_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_c0_ren,
   input  logic              i_c0_wen,
   input  logic [ADDR_W-1:0] i_c0_addr,
   input  logic [DATA_W-1:0] i_c0_store,
   output logic              o_c0_wait,
   output logic [DATA_W-1:0] o_c0_load,
   input  logic              i_c1_ren,
   input  logic              i_c1_wen,
   input  logic [ADDR_W-1:0] i_c1_addr,
   input  logic [DATA_W-1:0] i_c1_store,
   output logic              o_c1_wait,
   output logic [DATA_W-1:0] o_c1_load,
   output logic              o_ram_ren,
   output logic              o_ram_wen,
   output logic [ADDR_W-1:0] o_ram_addr,
   output logic [DATA_W-1:0] o_ram_store,
   input  logic [DATA_W-1:0] i_ram_load,
   input  logic [1:0]        i_ram_state,
   output logic              o_grant,
   output logic              o_busy,
   output logic              o_err
);
   localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
   localparam logic [TW-1:0] T_MAX = '1;
   localparam logic [1:0] ST_ACCESS = 2'd2;
   localparam logic [1:0] ST_ERROR = 2'd3;
   typedef enum logic {IDLE, SERVE} state_t;
   state_t r_fsm, w_fsm_nxt;
   logic r_owner, w_owner_nxt, r_last, w_last_nxt;
   logic [TW-1:0] r_tcnt, w_tcnt_nxt;
   logic w_req0, w_req1, w_serve, w_oreq, w_oren, w_owen;
   logic w_acc, w_rerr, w_tout, w_done, w_exit;
   assign w_req0  = i_c0_ren | i_c0_wen;
   assign w_req1  = i_c1_ren | i_c1_wen;
   assign w_serve = (r_fsm == SERVE);
   assign w_oreq  = r_owner ? w_req1 : w_req0;
   assign w_oren  = r_owner ? i_c1_ren : i_c0_ren;
   assign w_owen  = r_owner ? i_c1_wen : i_c0_wen;
   // Exit causes in priority order: ACCESS, ERROR, abort, timeout.
   assign w_acc   = w_serve & (i_ram_state == ST_ACCESS);
   assign w_rerr  = w_serve & (i_ram_state == ST_ERROR);
   assign w_tout  = w_serve & w_oreq & ~w_acc & ~w_rerr & (r_tcnt == T_LAST);
   assign w_done  = w_acc | w_rerr | w_tout;
   assign w_exit  = w_done | (w_serve & ~w_oreq);
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_fsm   <= IDLE;
         r_owner <= 1'b0;
         r_last  <= 1'b1;
         r_tcnt  <= '0;
      end else begin
         r_fsm   <= w_fsm_nxt;
         r_owner <= w_owner_nxt;
         r_last  <= w_last_nxt;
         r_tcnt  <= w_tcnt_nxt;
      end
   end
   always_comb begin
      w_fsm_nxt   = r_fsm;
      w_owner_nxt = r_owner;
      w_last_nxt  = r_last;
      w_tcnt_nxt  = r_tcnt;
      if (!w_serve) begin
         if (w_req0 | w_req1) begin
            w_fsm_nxt   = SERVE;
            w_owner_nxt = (w_req0 & w_req1) ? ~r_last : w_req1;
            w_tcnt_nxt  = '0;
         end
      end else if (w_exit) begin
         w_fsm_nxt  = IDLE;
         w_tcnt_nxt = '0;
         w_last_nxt = w_done ? r_owner : r_last;
      end else begin
         w_tcnt_nxt = (r_tcnt == T_MAX) ? r_tcnt : r_tcnt + 1'b1;
      end
   end
   assign o_ram_wen   = w_serve & w_owen;
   assign o_ram_ren   = w_serve & w_oren & ~w_owen;
   assign o_ram_addr  = w_serve ? (r_owner ? i_c1_addr : i_c0_addr) : '0;
   assign o_ram_store = w_serve ? (r_owner ? i_c1_store : i_c0_store) : '0;
   assign o_c0_wait   = w_req0 & ~(w_done & ~r_owner);
   assign o_c1_wait   = w_req1 & ~(w_done & r_owner);
   assign o_c0_load   = (w_acc & ~r_owner) ? i_ram_load : '0;
   assign o_c1_load   = (w_acc & r_owner) ? i_ram_load : '0;
   assign o_grant     = r_owner;
   assign o_busy      = w_serve;
   assign o_err       = w_rerr | w_tout;
endmodule

// File: tb/tb_dual_core_mem_arbiter.sv
// tb_dual_core_mem_arbiter: directed and randomized checks of the arbiter against
// a transaction-level model of the sharing rules.
module tb_dual_core_mem_arbiter;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int TO = 4;
   logic clk = 1'b0, rst = 1'b1;
   logic c0_ren = 0, c0_wen = 0, c1_ren = 0, c1_wen = 0;
   logic [AW-1:0] c0_addr = '0, c1_addr = '0;
   logic [DW-1:0] c0_store = '0, c1_store = '0, ram_load = '0;
   logic [1:0] ram_state = 2'd1;
   logic c0_wait, c1_wait, ram_ren, ram_wen, grant, busy, err;
   logic [DW-1:0] c0_load, c1_load, ram_store;
   logic [AW-1:0] ram_addr;
   bit m_serve, m_owner, m_last;
   int m_age;
   int n_chk = 0, n_pass = 0, n_fail = 0;
   always #5 clk = ~clk;
   dual_core_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
      .i_clk(clk), .i_rst(rst),
      .i_c0_ren(c0_ren), .i_c0_wen(c0_wen), .i_c0_addr(c0_addr), .i_c0_store(c0_store),
      .o_c0_wait(c0_wait), .o_c0_load(c0_load),
      .i_c1_ren(c1_ren), .i_c1_wen(c1_wen), .i_c1_addr(c1_addr), .i_c1_store(c1_store),
      .o_c1_wait(c1_wait), .o_c1_load(c1_load),
      .o_ram_ren(ram_ren), .o_ram_wen(ram_wen), .o_ram_addr(ram_addr), .o_ram_store(ram_store),
      .i_ram_load(ram_load), .i_ram_state(ram_state),
      .o_grant(grant), .o_busy(busy), .o_err(err)
   );
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic model_reset();
      m_serve = 0; m_owner = 0; m_last = 1; m_age = 0;
   endtask
   // Expected outputs for the current cycle, derived from the access rules.
   task automatic check_all();
      bit r0, r1, oreq, acc, rerr, tmo, acked, wen, ren;
      logic [AW-1:0] addr;
      logic [DW-1:0] st;
      r0 = c0_ren | c0_wen;
      r1 = c1_ren | c1_wen;
      oreq = m_owner ? r1 : r0;
      acc = m_serve && ram_state == 2'd2;
      rerr = m_serve && ram_state == 2'd3;
      tmo = m_serve && !acc && !rerr && oreq && m_age == TO - 1;
      acked = acc || rerr || tmo;
      wen = m_serve && (m_owner ? c1_wen : c0_wen);
      ren = m_serve && !wen && (m_owner ? c1_ren : c0_ren);
      addr = !m_serve ? '0 : m_owner ? c1_addr : c0_addr;
      st = !m_serve ? '0 : m_owner ? c1_store : c0_store;
      chk("c0_wait", c0_wait, r0 && !(acked && m_owner == 0));
      chk("c1_wait", c1_wait, r1 && !(acked && m_owner == 1));
      chk("c0_load", c0_load, (acc && m_owner == 0) ? ram_load : 0);
      chk("c1_load", c1_load, (acc && m_owner == 1) ? ram_load : 0);
      chk("ram_ren", ram_ren, ren);
      chk("ram_wen", ram_wen, wen);
      chk("ram_addr", ram_addr, addr);
      chk("ram_store", ram_store, st);
      chk("grant", grant, m_owner);
      chk("busy", busy, m_serve);
      chk("err", err, rerr || tmo);
   endtask
   task automatic advance();
      bit r0, r1, oreq;
      r0 = c0_ren | c0_wen;
      r1 = c1_ren | c1_wen;
      oreq = m_owner ? r1 : r0;
      if (!m_serve) begin
         if (r0 || r1) begin
            m_serve = 1;
            m_owner = (r0 && r1) ? !m_last : r1;
            m_age = 0;
         end
      end else if (ram_state >= 2'd2 || (oreq && m_age == TO - 1)) begin
         m_last = m_owner;
         m_serve = 0;
      end else if (!oreq) m_serve = 0;
      else m_age++;
   endtask
   task automatic cycle();
      #1 check_all();
      @(posedge clk);
      advance();
      @(negedge clk);
   endtask
   task automatic do_reset();
      rst = 1;
      model_reset();
      @(negedge clk);
      check_all();
      rst = 0;
   endtask
   initial begin
      int k;
      @(negedge clk);
      do_reset();
      // single read, ACCESS on second SERVE cycle
      c0_ren = 1; c0_addr = 32'h40; ram_state = 2'd1;
      cycle();
      cycle();
      ram_state = 2'd2; ram_load = 32'hDEADBEEF;
      #1 chk("t1_load", c0_load, 32'hDEADBEEF);
      cycle();
      c0_ren = 0; ram_state = 2'd0;
      cycle();
      // both cores contend continuously
      do_reset();
      c0_ren = 1; c1_ren = 1; c0_addr = 32'h100; c1_addr = 32'h200; ram_state = 2'd2;
      k = 0;
      for (int i = 0; i < 8; i++) begin
         #1 if (busy) begin
            chk("t2_grant", grant, k % 2);
            k++;
         end
         cycle();
      end
      chk("t2_wins", k, 4);
      c0_ren = 0; c1_ren = 0;
      cycle();
      // write wins over read
      c1_ren = 1; c1_wen = 1; c1_addr = 32'h80; c1_store = 32'h1234; ram_state = 2'd1;
      cycle();
      #1 chk("t3_wen", ram_wen, 1);
      chk("t3_ren", ram_ren, 0);
      chk("t3_store", ram_store, 32'h1234);
      chk("t3_addr", ram_addr, 32'h80);
      cycle();
      ram_state = 2'd2;
      cycle();
      c1_ren = 0; c1_wen = 0;
      cycle();
      // timeout with RAM stuck BUSY
      c0_ren = 1; ram_state = 2'd1;
      for (int i = 0; i < 4; i++) cycle();
      #1 chk("t4_err", err, 1);
      chk("t4_wait", c0_wait, 0);
      cycle();
      chk("t4_idle", busy, 0);
      c0_ren = 0;
      cycle();
      // RAM ERROR, then the other core is served
      c0_ren = 1; c1_ren = 1; ram_state = 2'd1;
      cycle();
      ram_state = 2'd3;
      cycle();
      ram_state = 2'd2;
      for (int i = 0; i < 4; i++) cycle();
      // reset in the middle of an access
      c0_ren = 0; c1_ren = 0;
      cycle();
      c1_ren = 1; ram_state = 2'd1;
      cycle();
      cycle();
      rst = 1;
      model_reset();
      #1 chk("t6_ren", ram_ren, 0);
      chk("t6_busy", busy, 0);
      check_all();
      @(negedge clk);
      rst = 0;
      c0_ren = 1;
      cycle();
      #1 chk("t6_tie", grant, 0);
      for (int i = 0; i < 3; i++) cycle();
      // randomized traffic
      for (int i = 0; i < 500; i++) begin
         int v;
         if ($urandom_range(0, 3) == 0) begin
            c0_ren = $urandom_range(0, 1); c0_wen = $urandom_range(0, 2) == 0;
         end
         if ($urandom_range(0, 3) == 0) begin
            c1_ren = $urandom_range(0, 1); c1_wen = $urandom_range(0, 2) == 0;
         end
         c0_addr = $urandom; c1_addr = $urandom;
         c0_store = $urandom; c1_store = $urandom; ram_load = $urandom;
         v = $urandom_range(0, 9);
         ram_state = v < 5 ? 2'd1 : v < 8 ? 2'd2 : v == 8 ? 2'd3 : 2'd0;
         cycle();
      end
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
